// File: rtl/koggstone_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// The beat state moves through one generate block per operation: pg, LOG2(WIDTH) prefix levels, sum.
module koggstone_pipe_adder #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int LVL    = $clog2(WIDTH);
   localparam int NOPS   = LVL + 2;
   localparam int NEXT   = LATENCY - 1;
   localparam int NEXT_D = (NEXT > 0) ? NEXT : 1;

   // h = half-sum (later the sum), g/pr = prefix generate/propagate, c = carry-in (later carry-out).
   // After the sum operation, g[0] carries the overflow flag.
   typedef struct packed {
      logic [WIDTH-1:0] h;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] pr;
      logic             c;
   } st_t;

   // Extra bank k follows operation (k*NOPS)/NEXT - 1, so the last bank always registers the outputs.
   function automatic int cut_bank(input int op);
      int res;
      res = 0;
      for (int k = 1; k <= NEXT; k++) begin
         if ((k * NOPS) / NEXT_D == op + 1) res = k;
      end
      return res;
   endfunction

   logic               w_stall;
   logic               w_en;
   logic [LATENCY-1:0] r_vld;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_c;
   logic               w_unused;

   assign w_stall   = r_vld[LATENCY-1] & ~out_ready;
   assign w_en      = ~w_stall;
   assign in_ready  = ~w_stall;
   assign out_valid = r_vld[LATENCY-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else if (w_en) begin
         r_vld[0] <= in_valid;
         for (int k = 1; k < LATENCY; k++) r_vld[k] <= r_vld[k-1];
      end
   end

   // The mode is folded into the operands here and needs no further pipelining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
         r_c <= 1'b0;
      end else if (w_en) begin
         r_a <= a;
         r_b <= sub ? ~b : b;
         r_c <= ci ^ sub;
      end
   end

   for (genvar gi = 0; gi < NOPS; gi++) begin : g_op
      localparam int BANK = cut_bank(gi);
      st_t w_src;
      st_t w_res;
      st_t w_out;

      if (gi == 0) begin : g_first
         assign w_src = '{h: r_a, g: r_b, pr: '0, c: r_c};
      end else begin : g_chain
         assign w_src = g_op[gi-1].w_out;
      end

      if (gi == 0) begin : g_pg
         // Carry-in is merged into bit 0's generate so LVL levels suffice.
         always_comb begin
            w_res      = w_src;
            w_res.h    = w_src.h ^ w_src.g;
            w_res.pr   = w_src.h ^ w_src.g;
            w_res.g    = w_src.h & w_src.g;
            w_res.g[0] = (w_src.h[0] & w_src.g[0]) | ((w_src.h[0] ^ w_src.g[0]) & w_src.c);
         end
      end else if (gi <= LVL) begin : g_lvl
         localparam int SPAN = 1 << (gi - 1);
         always_comb begin
            w_res = w_src;
            for (int i = SPAN; i < WIDTH; i++) begin
               w_res.g[i]  = w_src.g[i] | (w_src.pr[i] & w_src.g[i-SPAN]);
               w_res.pr[i] = w_src.pr[i] & w_src.pr[i-SPAN];
            end
         end
      end else begin : g_sum
         logic [WIDTH-1:0] w_cin;
         assign w_cin = {w_src.g[WIDTH-2:0], w_src.c};
         always_comb begin
            w_res      = '0;
            w_res.h    = w_src.h ^ w_cin;
            w_res.c    = w_src.g[WIDTH-1];
            w_res.g[0] = w_cin[WIDTH-1] ^ w_src.g[WIDTH-1];
         end
      end

      if (BANK != 0) begin : g_reg
         st_t r_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    r_q <= '0;
            else if (w_en) r_q <= w_res;
         end
         assign w_out = r_q;
      end else begin : g_thru
         assign w_out = w_res;
      end
   end

   assign s   = g_op[NOPS-1].w_out.h;
   assign co  = g_op[NOPS-1].w_out.c;
   assign ovf = g_op[NOPS-1].w_out.g[0];

   // Fields the state carries but no later operation reads.
   assign w_unused = ^{g_op[0].w_src.pr, g_op[NOPS-1].w_src.pr,
                       g_op[NOPS-1].w_out.pr, g_op[NOPS-1].w_out.g[WIDTH-1:1]};

endmodule

// File: tb/tb_koggstone_pipe_adder.sv
// Scoreboard bench for koggstone_pipe_adder: directed beats, backpressure, mid-stream reset, random stream.
module tb_koggstone_pipe_adder;
   localparam int W   = 32;
   localparam int LAT = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         ci = 1'b0;
   logic         sub = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] s;
   logic         co;
   logic         ovf;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ovf;
      int           cyc;
      int           stl;
   } exp_t;

   exp_t         q[$];
   int           n_tests = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           stl = 0;
   logic [W-1:0] e_s = '0;
   logic         e_co = 1'b0;
   logic         e_ovf = 1'b0;
   logic         held_ok = 1'b0;
   logic [W+1:0] held = '0;
   logic         rnd_done = 1'b0;

   koggstone_pipe_adder #(.WIDTH(W), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Returns {ovf, co, s}; overflow from operand/result signs.
   function automatic logic [W+1:0] model(input logic [W-1:0] ta, tb, input logic tci, tsub);
      logic [W-1:0] be;
      logic [W:0]   r;
      logic         v;
      be = tsub ? ~tb : tb;
      r  = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, tci ^ tsub};
      v  = (ta[W-1] == be[W-1]) && (r[W-1] != ta[W-1]);
      return {v, r};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         held_ok = 1'b0;
      end else begin
         cyc++;
         chk("in_ready", {63'b0, in_ready}, {63'b0, !(out_valid && !out_ready)});
         if (held_ok) chk("frozen", {30'b0, ovf, co, s}, {30'b0, held});
         held_ok = out_valid && !out_ready;
         held    = {ovf, co, s};
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_valid", {63'b0, out_valid}, 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               $display("[TB] out s=%h co=%b ovf=%b exp s=%h co=%b ovf=%b", s, co, ovf, e.s, e.co, e.ovf);
               chk("s", {32'b0, s}, {32'b0, e.s});
               chk("co", {63'b0, co}, {63'b0, e.co});
               chk("ovf", {63'b0, ovf}, {63'b0, e.ovf});
               chk("latency", 64'(cyc - e.cyc - (stl - e.stl)), 64'(LAT));
            end
         end
         if (in_valid && in_ready) q.push_back('{e_s, e_co, e_ovf, cyc, stl});
         if (out_valid && !out_ready) stl++;
      end
   end

   task automatic beat(input logic [W-1:0] ta, tb, input logic tci, tsub,
                       input logic [W-1:0] es, input logic eco, eovf);
      a = ta; b = tb; ci = tci; sub = tsub;
      e_s = es; e_co = eco; e_ovf = eovf;
      in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic rbeat(input logic [W-1:0] ta, tb, input logic tci, tsub);
      logic [W+1:0] m;
      m = model(ta, tb, tci, tsub);
      beat(ta, tb, tci, tsub, m[W-1:0], m[W], m[W+1]);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk("drain", 64'(q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(5))
         0:       v = 32'hFFFF_FFFF;
         1:       v = 32'h7FFF_FFFF;
         2:       v = 32'h8000_0000;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_s", {32'b0, s}, 64'd0);
      chk("rst_co_ovf", {62'b0, co, ovf}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;

      beat(32'd5, 32'd10, 1'b1, 1'b0, 32'd16, 1'b0, 1'b0);
      beat(32'd127, 32'd127, 1'b1, 1'b0, 32'd255, 1'b0, 1'b0);
      beat(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      beat(32'd37, 32'd48, 1'b0, 1'b1, 32'hFFFF_FFF5, 1'b0, 1'b0);
      beat(32'd48, 32'd37, 1'b1, 1'b1, 32'd10, 1'b1, 1'b0);
      beat(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      drain();

      fork
         begin
            for (int i = 0; i < 8; i++)
               beat(W'(i), W'(i), 1'b0, 1'b0, W'(2 * i), 1'b0, 1'b0);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 3; i++)
         beat(W'(i + 1), 32'd7, 1'b0, 1'b0, W'(i + 8), 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("midrst_s", {32'b0, s}, 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_idle", {63'b0, out_valid}, 64'd0);
      end
      @(posedge clk); #1;
      beat(32'd3, 32'd90, 1'b1, 1'b0, 32'd94, 1'b0, 1'b0);
      drain();

      fork
         begin
            for (int n = 0; n < 3000; n++) begin
               if ($urandom_range(3) == 0) idle();
               rbeat(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(3) != 0);
            end
         end
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
